// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, MemSize codes,
// and the byte-lane write request passed to the storage array.
package dmem_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] MSZ_B  = 3'b000;
  localparam logic [2:0] MSZ_H  = 3'b001;
  localparam logic [2:0] MSZ_W  = 3'b010;
  localparam logic [2:0] MSZ_BU = 3'b100;
  localparam logic [2:0] MSZ_HU = 3'b101;

  typedef logic [NUM_LANES-1:0][7:0] word_t;

  typedef struct packed {
    logic                 we;
    logic [NUM_LANES-1:0] be;
    word_t                data;
  } wr_req_t;

  function automatic logic is_byte(input logic [2:0] sz);
    return (sz == MSZ_B) || (sz == MSZ_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] sz);
    return (sz == MSZ_H) || (sz == MSZ_HU);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage split into byte lanes: synchronous byte-enable
// write, combinational read. Contents are never reset.
module dmem_array import dmem_pkg::*; #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_addr,
  input  wr_req_t       i_wr,
  output word_t         o_rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk)
      if (i_wr.we && i_wr.be[l]) r_mem[i_addr] <= i_wr.data[l];

    assign o_rdata[l] = r_mem[i_addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the core WAIT_STATES+1 cycles
// per access, then completes the load/store in DONE.
// Optional: define DMEM_MISALIGN_CHECK_EN to flag and suppress misaligned accesses.
module dmem_responder import dmem_pkg::*; #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       MemSize,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] ReadData,
  output logic             stall,
  output logic             MisAlign
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_misal;

  logic        w_req, w_enter_done, w_byte, w_half, w_misal;
  logic [1:0]  w_boff;
  word_t       w_rword;
  logic [31:0] w_word, w_ld;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  wr_req_t     w_wr;
  logic        w_unused_addr;

  assign w_req  = MemRead | MemWrite;
  assign w_byte = is_byte(MemSize);
  assign w_half = is_half(MemSize);
  assign w_boff = ALUResult[1:0];

  assign stall        = ((r_state == S_IDLE) && w_req) || (r_state == S_WAIT);
  assign w_enter_done = ((r_state == S_IDLE) && w_req && (WAIT_STATES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misal = w_half ? w_boff[0] : (w_byte ? 1'b0 : (w_boff != 2'b00));
`else
  assign w_misal = 1'b0;
`endif

  // Without the check, natural alignment falls out of ignoring the low
  // offset bits that a half/word access does not use.
  assign w_word = w_rword;
  assign w_b    = w_word[8*w_boff +: 8];
  assign w_h    = w_boff[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ld = w_word;
    if (w_byte)      w_ld = MemSize[2] ? {24'b0, w_b} : {{24{w_b[7]}}, w_b};
    else if (w_half) w_ld = MemSize[2] ? {16'b0, w_h} : {{16{w_h[15]}}, w_h};
  end

  // Store data is replicated across lanes; byte enables pick the target.
  always_comb begin
    w_wr.we   = w_enter_done & MemWrite & ~w_misal;
    w_wr.be   = 4'hF;
    w_wr.data = WriteData[31:0];
    if (w_byte) begin
      w_wr.be   = 4'b0001 << w_boff;
      w_wr.data = {4{WriteData[7:0]}};
    end else if (w_half) begin
      w_wr.be   = w_boff[1] ? 4'b1100 : 4'b0011;
      w_wr.data = {2{WriteData[15:0]}};
    end
  end

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .i_addr  (ALUResult[AW+1:2]),
    .i_wr    (w_wr),
    .o_rdata (w_rword)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_misal  <= 1'b0;
      ReadData <= '0;
    end else begin
      r_misal <= 1'b0;
      case (r_state)
        S_IDLE: if (w_req) begin
          if (WAIT_STATES == 0) r_state <= S_DONE;
          else begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        S_WAIT: if (r_cnt == 4'd0) r_state <= S_DONE;
                else               r_cnt   <= r_cnt - 4'd1;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_enter_done) begin
        r_misal <= w_misal;
        // Read+write together is a store, so ReadData holds.
        if (MemRead && !MemWrite) ReadData <= w_misal ? '0 : WIDTH'(w_ld);
      end
    end
  end

  assign MisAlign      = r_misal;
  assign w_unused_addr = &{1'b0, ALUResult[WIDTH-1:AW+2]};

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter DEPTH, default 256, number of 32-bit words stored.
REQ-003 SHALL have parameter WAIT_STATES, default 2, extra stall cycles per access (legal 0..15).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port MemRead  input  1  load request from core.
REQ-007 SHALL have port MemWrite  input  1  store request from core.
REQ-008 SHALL have port MemSize  input  3  funct3 size code: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 SHALL have port ALUResult  input  WIDTH  byte address.
REQ-010 SHALL have port WriteData  input  WIDTH  store data, right-aligned.
REQ-011 SHALL have port ReadData  output  WIDTH  load data, extended per MemSize.
REQ-012 SHALL have port stall  output  1  freeze request to core PC mux.
REQ-013 SHALL have port MisAlign  output  1  misaligned-access flag.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE; req = MemRead | MemWrite.
REQ-015 SHALL drive stall combinationally high in IDLE while req=1 and in every WAIT cycle; low in DONE and in IDLE with req=0.
REQ-016 IDLE with req=1 SHALL go to WAIT with counter=WAIT_STATES-1, or directly to DONE when WAIT_STATES=0; IDLE with req=0 stays IDLE.
REQ-017 WAIT SHALL go to DONE when counter=0, else decrement counter.
REQ-018 DONE SHALL go to IDLE unconditionally; a req present in the following IDLE cycle starts a new access.
REQ-019 Total stall per access SHALL be exactly WAIT_STATES+1 cycles; access completes in cycle WAIT_STATES+2.
REQ-020 Address, size, data SHALL be sampled on the cycle entering DONE; core holds them stable while stall=1.
REQ-021 ReadData SHALL be registered, loaded on entry to DONE for reads, held otherwise.
REQ-022 Stores SHALL write the array on the DONE clock edge using byte enables: SB one byte at addr[1:0], SH two bytes at addr[1], SW all four.
REQ-023 LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend; undefined MemSize codes SHALL behave as LW/SW.
REQ-024 Word index SHALL be ALUResult[log2(DEPTH)+1:2]; higher address bits ignored (wrap modulo DEPTH*4).
REQ-025 MemRead and MemWrite both high SHALL be treated as a store; ReadData not updated.
REQ-026 A load following a store to the same word SHALL return the newly written data.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE, counter 0, ReadData 0, MisAlign 0; array contents not reset.
REQ-028 Reset during WAIT SHALL abort the access with no array write; after release, a held req restarts a full access.

Configuration
REQ-029 With DMEM_MISALIGN_CHECK_EN defined, an access with LH/LHU/SH at addr[0]=1 or LW/SW at addr[1:0]!=0 SHALL keep normal timing, suppress the write, load ReadData=0, and assert MisAlign for the DONE cycle only.
REQ-030 Without DMEM_MISALIGN_CHECK_EN, MisAlign SHALL be tied 0 and the address rounded down to natural alignment of the size.

Structure
REQ-031 Package dmem_pkg SHALL hold the state enum and the MemSize code constants.
REQ-032 Storage SHALL be sub-module dmem_array: byte-enable synchronous write, combinational read.

Verification (WAIT_STATES=2)
REQ-033 SW 0xDEADBEEF @0x10, then LW @0x10 -> stall high 3 cycles each, ReadData=0xDEADBEEF in DONE.
REQ-034 SB 0x80 @0x13 over 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
REQ-035 Back-to-back LW @0x0 then LW @0x4 with req held -> stall pattern 1,1,1,0,1,1,1,0; no lost access.
REQ-036 reset_n pulsed low in second WAIT cycle of SW 0x12345678 @0x20 -> no write; LW @0x20 returns prior value.
REQ-037 With macro, LW @0x22 -> MisAlign=1 one cycle, ReadData=0; SW @0x22 leaves 0x20 word unchanged.
REQ-038 Address 0x400 with DEPTH=256 -> aliases word 0.
